// File: rtl/led_ring_pkg.sv
// -----------------------------------------------------------------------------
// led_ring_pkg
// Shared constants, FSM encoding and small arithmetic helpers for the LED ring
// controller.
//   NUM_LEDS          number of LEDs on the ring (one-hot mask width)
//   FRAME_CYCLES_DEF  default minimum refresh spacing in clk cycles
//   INT_STEP_DEF      default intensity change per encoder step
//   COL_RST/INTEN_RST shadow reset values for colour and intensity
//   state_t           controller FSM encoding
// -----------------------------------------------------------------------------
package led_ring_pkg;

   localparam int NUM_LEDS         = 12;
   localparam int POS_W            = 4;
   localparam int CNT_W            = 15;
   localparam int FRAME_CYCLES_DEF = 20000;
   localparam int INT_STEP_DEF     = 16;

   localparam logic [2:0] COL_RST   = 3'b001;
   localparam logic [7:0] INTEN_RST = 8'h20;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   // Ring position +1 with wrap from the last LED back to LED 0.
   function automatic logic [POS_W-1:0] pos_inc(input logic [POS_W-1:0] p);
      return (p == POS_W'(NUM_LEDS - 1)) ? '0 : p + 1'b1;
   endfunction

   // Ring position -1 with wrap from LED 0 to the last LED.
   function automatic logic [POS_W-1:0] pos_dec(input logic [POS_W-1:0] p);
      return (p == '0) ? POS_W'(NUM_LEDS - 1) : p - 1'b1;
   endfunction

   // Colour advance 1..7; 0 (all LEDs dark) is never produced.
   function automatic logic [2:0] col_next(input logic [2:0] c);
      return (c == 3'd7) ? 3'd1 : c + 3'd1;
   endfunction

   // Saturating intensity arithmetic on a 9-bit intermediate so the carry
   // and borrow are visible instead of wrapping.
   function automatic logic [7:0] inten_up(input logic [7:0] v, input logic [8:0] step);
      logic [8:0] s;
      s = {1'b0, v} + step;
      return s[8] ? 8'hFF : s[7:0];
   endfunction

   function automatic logic [7:0] inten_down(input logic [7:0] v, input logic [8:0] step);
      logic [8:0] s;
      s = {1'b0, v} - step;
      return ({1'b0, v} < step) ? 8'h00 : s[7:0];
   endfunction

   function automatic logic [NUM_LEDS-1:0] pos_mask(input logic [POS_W-1:0] p);
      return NUM_LEDS'(1) << p;
   endfunction

endpackage

// File: rtl/led_ring_ctrl_if.sv
// -----------------------------------------------------------------------------
// led_ring_ctrl_if
// Bundles the encoder/button events and the ring-driver outputs.
//   step_up, step_down, btn_colour, btn_mode : event strobes into the controller
//   refresh, led_mask, colour, intensity     : frame outputs to the ring driver
//   mode                                     : current edit mode (0 pos, 1 bright)
//   fsm_state                                : controller state, for observation
// Handshake: every signal here is a single-cycle strobe or a level. There is
// no ready/valid pairing -- an input strobe is consumed on the clk edge where
// it is high, and refresh marks the one cycle in which a new frame appears on
// led_mask/colour/intensity; the driver cannot stall the controller.
// -----------------------------------------------------------------------------
interface led_ring_ctrl_if;
   import led_ring_pkg::*;

   logic                step_up;
   logic                step_down;
   logic                btn_colour;
   logic                btn_mode;
   logic                refresh;
   logic [NUM_LEDS-1:0] led_mask;
   logic [2:0]          colour;
   logic [7:0]          intensity;
   logic                mode;
   state_t              fsm_state;

   // Event source / driver side.
   modport master (
      output step_up, step_down, btn_colour, btn_mode,
      input  refresh, led_mask, colour, intensity, mode, fsm_state
   );

   // Controller side.
   modport slave (
      input  step_up, step_down, btn_colour, btn_mode,
      output refresh, led_mask, colour, intensity, mode, fsm_state
   );
endinterface

// File: rtl/frame_timer.sv
// -----------------------------------------------------------------------------
// frame_timer
// Down-counter that times the HOLD part of a frame.
//   clk, res_n : clock, synchronous active-low reset (counter -> 0)
//   load       : load load_val into the counter
//   run        : count down towards zero (stops at zero)
//   load_val   : start value
//   tc         : terminal count, high while running with the counter at zero
// -----------------------------------------------------------------------------
module frame_timer
   import led_ring_pkg::*;
(
   input  logic             clk,
   input  logic             res_n,
   input  logic             load,
   input  logic             run,
   input  logic [CNT_W-1:0] load_val,
   output logic             tc
);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (!res_n) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= load_val;
      end else if (run && (cnt_q != '0)) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign tc = run && (cnt_q == '0);

endmodule

// File: rtl/led_ring_ctrl.sv
// -----------------------------------------------------------------------------
// led_ring_ctrl
// Turns encoder steps and button presses into rate-limited frames for an
// addressable 12-LED ring driver.
//   clk   : system clock
//   res_n : synchronous active-low reset
//   bus   : event inputs and frame outputs (see led_ring_ctrl_if)
// Parameters:
//   FRAME_CYCLES : minimum cycles between refresh pulses (2 .. 32769)
//   INT_STEP     : intensity change per encoder step
// Events update shadow registers at any time; a dirty flag asks the FSM to
// publish them. A frame is IDLE -> LOAD (refresh, 1 cycle) -> HOLD
// (FRAME_CYCLES-1 cycles) -> IDLE, so back-to-back refreshes are
// FRAME_CYCLES+1 cycles apart and events during HOLD merge into one frame.
// -----------------------------------------------------------------------------
module led_ring_ctrl
   import led_ring_pkg::*;
#(
   parameter int FRAME_CYCLES = FRAME_CYCLES_DEF,
   parameter int INT_STEP     = INT_STEP_DEF
) (
   input  logic           clk,
   input  logic           res_n,
   led_ring_ctrl_if.slave bus
);

   // LOAD loads FRAME_CYCLES-2 so the counter reaches zero on the last of
   // the FRAME_CYCLES-1 HOLD cycles.
   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(FRAME_CYCLES - 2);
   localparam logic [8:0]       STEP9     = 9'(INT_STEP);

   state_t state_q, state_d;

   logic [POS_W-1:0]    pos_q, pos_d;
   logic [2:0]          col_q, col_d;
   logic [7:0]          inten_q, inten_d;
   logic                mode_q, mode_d;
   logic                dirty_q;
   logic                changed;
   logic                step_valid;

   logic [NUM_LEDS-1:0] mask_q;
   logic [2:0]          colour_q;
   logic [7:0]          intensity_q;

   logic                tmr_load, tmr_run, tmr_tc;
   logic                refresh;

   // ---------------- shadow update ----------------
   always_comb begin
      pos_d      = pos_q;
      col_d      = col_q;
      inten_d    = inten_q;
      mode_d     = mode_q;
      step_valid = bus.step_up ^ bus.step_down;
      // Steps are interpreted under the mode in effect before this edge,
      // so a simultaneous btn_mode does not redirect them.
      if (step_valid) begin
         if (!mode_q) begin
            pos_d = bus.step_up ? pos_inc(pos_q) : pos_dec(pos_q);
         end else begin
            inten_d = bus.step_up ? inten_up(inten_q, STEP9) : inten_down(inten_q, STEP9);
         end
      end
      if (bus.btn_colour) begin
         col_d = col_next(col_q);
      end
      if (bus.btn_mode) begin
         mode_d = ~mode_q;
      end
   end

   // Only a real value change requests a frame; saturated or cancelled
   // events leave dirty alone.
   assign changed = (pos_d != pos_q) || (col_d != col_q) ||
                    (inten_d != inten_q) || (mode_d != mode_q);

   always_ff @(posedge clk) begin
      if (!res_n) begin
         pos_q   <= '0;
         col_q   <= COL_RST;
         inten_q <= INTEN_RST;
         mode_q  <= 1'b0;
         dirty_q <= 1'b1;
      end else begin
         pos_q   <= pos_d;
         col_q   <= col_d;
         inten_q <= inten_d;
         mode_q  <= mode_d;
         // LOAD publishes the current shadows; a change landing on the same
         // edge is not in that frame, so it keeps dirty set.
         if (state_q == ST_LOAD) begin
            dirty_q <= changed;
         end else if (changed) begin
            dirty_q <= 1'b1;
         end
      end
   end

   // ---------------- frame FSM ----------------
   always_ff @(posedge clk) begin
      if (!res_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      tmr_load = 1'b0;
      tmr_run  = 1'b0;
      refresh  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (dirty_q) begin
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            refresh  = 1'b1;
            tmr_load = 1'b1;
            state_d  = ST_HOLD;
         end
         ST_HOLD: begin
            tmr_run = 1'b1;
            if (tmr_tc) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   frame_timer u_frame_timer (
      .clk      (clk),
      .res_n    (res_n),
      .load     (tmr_load),
      .run      (tmr_run),
      .load_val (HOLD_LOAD),
      .tc       (tmr_tc)
   );

   // ---------------- driver outputs ----------------
   // Output registers capture the shadows at the end of LOAD; during LOAD the
   // shadows are shown directly so the new frame coincides with refresh.
   always_ff @(posedge clk) begin
      if (!res_n) begin
         mask_q      <= '0;
         colour_q    <= '0;
         intensity_q <= '0;
      end else if (state_q == ST_LOAD) begin
         mask_q      <= pos_mask(pos_q);
         colour_q    <= col_q;
         intensity_q <= inten_q;
      end
   end

   assign bus.refresh   = refresh;
   assign bus.led_mask  = (state_q == ST_LOAD) ? pos_mask(pos_q) : mask_q;
   assign bus.colour    = (state_q == ST_LOAD) ? col_q : colour_q;
   assign bus.intensity = (state_q == ST_LOAD) ? inten_q : intensity_q;
   assign bus.mode      = mode_q;
   assign bus.fsm_state = state_q;

endmodule
